// File: rtl/smart_led_pkg.sv
// smart_led_pkg: frame layout constants and the receive state type shared by
// the smart-LED frame controller and its input synchronizer.
`timescale 1ns/1ps
package smart_led_pkg;

  localparam int FRAME_BITS = 32;
  localparam int DATA_BITS  = 30;
  localparam int USE_BIT    = 30;
  localparam int PARITY_BIT = 31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } frame_state_t;

endpackage

// File: rtl/smart_led_in_sync.sv
// smart_led_in_sync: brings the upstream serial clock/data into the clk
// domain through 2-FF synchronizers and produces a registered rising-edge
// pulse together with the data bit sampled in the same cycle.
`timescale 1ns/1ps
module smart_led_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic in_data,
  input  logic in_clock,
  output logic sample,
  output logic edge_pulse,
  output logic sync_clock
);

  logic clk_s1;
  logic clk_s2;
  logic clk_prev;
  logic data_s1;
  logic data_s2;

  // Two-stage synchronizers, then edge detect; the pulse and its data bit
  // are registered together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1     <= 1'b0;
      clk_s2     <= 1'b0;
      clk_prev   <= 1'b0;
      data_s1    <= 1'b0;
      data_s2    <= 1'b0;
      sample     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      clk_s1     <= in_clock;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      data_s1    <= in_data;
      data_s2    <= data_s1;
      sample     <= data_s2;
      edge_pulse <= clk_s2 & ~clk_prev;
    end
  end

  // Synchronized clock, aligned with the edge pulse.
  assign sync_clock = clk_prev;

endmodule

// File: rtl/smart_led_frame_ctrl.sv
// smart_led_frame_ctrl: receives 32-bit LSB-first frames, claims the first
// unclaimed frame after each latch gap, forwards the stream downstream with
// the use flag set on the claimed frame, and latches the claimed payload to
// the LED driver once the line has been idle for TIMEOUT cycles.
// Optional feature macro: SMART_LED_PARITY_CHECK_EN (when undefined, frames
// are treated as parity-good and forwarded parity is always regenerated).
`timescale 1ns/1ps
module smart_led_frame_ctrl
  import smart_led_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_data,
  input  logic                 in_clock,
  output logic                 out_data,
  output logic                 out_clock,
  output logic [DATA_BITS-1:0] led_data,
  output logic                 led_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 claimed
);

  logic                 sample;
  logic                 edge_pulse;
  logic                 sync_clock;

  frame_state_t         state;
  logic [4:0]           bit_cnt;
  logic [4:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] pending;
  logic [TO_W-1:0]      idle_cnt;
  logic                 tentative;
  logic                 fwd_par;
  logic                 fwd_bit;
  logic                 rx_bad;
  logic                 to_hit;
  logic                 oclk_d1;

  smart_led_in_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_clock   (in_clock),
    .sample     (sample),
    .edge_pulse (edge_pulse),
    .sync_clock (sync_clock)
  );

  // An edge outside SHIFT always starts a new frame at bit 0.
  assign bit_idx = (state == SHIFT) ? bit_cnt : 5'd0;

  // Timeout fires once, on the cycle the idle counter reaches TIMEOUT; an
  // edge in the same cycle takes priority.
  assign to_hit = !edge_pulse && (idle_cnt == TO_W'(TIMEOUT - 1));

`ifdef SMART_LED_PARITY_CHECK_EN
  logic rx_par;
  // Received frame is bad when the XOR over all 32 bits is nonzero.
  assign rx_bad = rx_par ^ sample;
`else
  assign rx_bad = 1'b0;
`endif

  // Bit to forward: use flag forced to 1 when this pixel claims, parity
  // regenerated over the forwarded bits (inverted for a bad input frame).
  always_comb begin
    fwd_bit = sample;
    if (bit_idx == 5'(USE_BIT)) begin
      fwd_bit = sample | ~claimed;
    end else if (bit_idx == 5'(PARITY_BIT)) begin
      fwd_bit = fwd_par ^ rx_bad;
    end
  end

`ifdef SMART_LED_PARITY_CHECK_EN
  // Running XOR of received bits 0..30 for the parity check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_par <= 1'b0;
    end else if (edge_pulse) begin
      rx_par <= (bit_idx == 5'd0) ? sample : (rx_par ^ sample);
    end
  end
`endif

  // Frame sequencer, claim/check logic, idle timeout and LED latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 5'd0;
      shift_reg    <= '0;
      pending      <= '0;
      idle_cnt     <= '0;
      tentative    <= 1'b0;
      fwd_par      <= 1'b0;
      out_data     <= 1'b0;
      led_data     <= '0;
      led_valid    <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      claimed      <= 1'b0;
    end else begin
      led_valid    <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      if (edge_pulse) begin
        idle_cnt <= '0;
        out_data <= fwd_bit;
        fwd_par  <= (bit_idx == 5'd0) ? fwd_bit : (fwd_par ^ fwd_bit);
        if (bit_idx < 5'(DATA_BITS)) begin
          shift_reg <= {sample, shift_reg[DATA_BITS-1:1]};
        end
        if (bit_idx == 5'(USE_BIT)) begin
          tentative <= ~sample & ~claimed;
        end
        if (state == SHIFT) begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'(FRAME_BITS - 1)) begin
            state     <= DONE;
            tentative <= 1'b0;
            if (rx_bad) begin
              parity_error <= 1'b1;
            end else if (tentative) begin
              pending <= shift_reg;
              claimed <= 1'b1;
            end
          end
        end else begin
          state   <= SHIFT;
          bit_cnt <= 5'd1;
        end
      end else begin
        if (idle_cnt != TO_W'(TIMEOUT)) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        if (to_hit) begin
          state     <= IDLE;
          bit_cnt   <= 5'd0;
          tentative <= 1'b0;
          if (state == SHIFT && bit_cnt != 5'd0) begin
            frame_error <= 1'b1;
          end
          if (claimed) begin
            led_data  <= pending;
            led_valid <= 1'b1;
            claimed   <= 1'b0;
          end
        end
      end
    end
  end

  // Downstream clock trails the edge pulse by two cycles so out_data leads
  // its rise by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oclk_d1   <= 1'b0;
      out_clock <= 1'b0;
    end else begin
      oclk_d1   <= sync_clock;
      out_clock <= oclk_d1;
    end
  end

endmodule

// File: doc/smart_led_frame_ctrl.md
# smart_led_frame_ctrl

Frame controller for one pixel of the smart-LED daisy chain. It samples the serial `in_data`/`in_clock` link, sequences 32-bit frames, and claims the first unclaimed frame after each latch gap for the local LED. It forwards the frame stream downstream with the use flag set on the claimed frame, then latches the claimed payload to the LED driver when the line goes idle.

## Interface
- `TIMEOUT`, 1000: idle clk cycles without an `in_clock` rising edge that end a frame train (latch gap).
- `TO_W`, 10: width of the idle counter; must satisfy 2^TO_W > TIMEOUT.
- `clk`  in  1  global clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  1  serial data from upstream, asynchronous to `clk`.
- `in_clock`  in  1  serial bit clock from upstream; rising edge marks a bit.
- `out_data`  out  1  serial data to downstream.
- `out_clock`  out  1  retimed bit clock to downstream.
- `led_data`  out  30  latched payload for the LED driver.
- `led_valid`  out  1  one-cycle pulse when `led_data` updates.
- `parity_error`  out  1  one-cycle pulse on a received frame with bad parity.
- `frame_error`  out  1  one-cycle pulse when a timeout aborts a partial frame.
- `claimed`  out  1  a frame has been claimed since the last latch.

## Operation
- Frame format: bits are sent LSB first, 32 per frame. Bits [29:0] are data, bit 30 is the use flag (0 = unclaimed), bit 31 is the parity bit. The frame is valid when the XOR of all 32 bits is 0.
- `in_clock` and `in_data` pass through 2-FF synchronizers. An edge pulse is raised when the synchronized clock is 1 and its previous value was 0. The sample is the synchronized `in_data` in the same cycle.
- State machine:
  - IDLE: on an edge, go to SHIFT with bit count 1.
  - SHIFT: each edge increments the 5-bit count and captures the bit into the shift register. The 32nd bit triggers the frame check and moves to DONE.
  - DONE: an edge starts a new frame in SHIFT with count 1. A timeout moves to IDLE.
- Timeout in any state:
  - SHIFT with count ≠ 0: pulse `frame_error`, discard the partial frame.
  - If `claimed`: `led_data` <= pending payload, pulse `led_valid`, clear `claimed`.
  - The idle counter saturates and clears on every edge.
- Claim at bit 30: tentative claim when the received flag is 0 and `claimed` is 0. Bit 30 is then forwarded as 1.
- Check at bit 31:
  - Tentative claim and parity good: store the 30-bit payload as pending, set `claimed`.
  - Parity bad: pulse `parity_error`, drop any tentative claim.
- Forwarding:
  - Every received bit is forwarded, with bit 30 replaced as described above.
  - Forwarded bit 31 is the running XOR of forwarded bits 0..30, inverted when the received frame had bad parity, so downstream also detects the error.
  - Unclaimed frames are forwarded bit-exact.
- Reset mid-operation discards all state; there is no partial recovery.

## Timing
- Reset values: `out_data`=0, `out_clock`=0, `led_data`=0, `led_valid`=0, `parity_error`=0, `frame_error`=0, `claimed`=0, state IDLE, counters 0.
- Latency to edge pulse: the edge pulse fires 3 clk after an `in_clock` rise at the pin.
- Downstream outputs:
  - `out_data` updates 1 clk after the edge pulse.
  - `out_clock` is the synchronized `in_clock` delayed 2 clk, so `out_data` leads the `out_clock` rise by 1 clk.
- Frame-check pulses:
  - `parity_error` pulses in the cycle after the 32nd edge pulse.
  - `claimed` rises in the cycle after the 32nd edge pulse.
- Latch: `led_valid` and `led_data` update in the cycle the idle counter reaches `TIMEOUT`.
- Upstream bit period must be ≥ 8 clk; high and low phases must each be ≥ 3 clk.
- An edge and a timeout in the same cycle: the edge wins, and the counter clears.

## Configuration
- `SMART_LED_PARITY_CHECK_EN` defined:
  - Parity is checked as above.
- `SMART_LED_PARITY_CHECK_EN` undefined:
  - Frames are always treated as parity-good.
  - `parity_error` is tied to 0.
  - Forwarded parity is always regenerated correct.

## Structure
- Package `smart_led_pkg` holds:
  - `FRAME_BITS`=32, `DATA_BITS`=30, `USE_BIT`=30, `PARITY_BIT`=31;
  - the state enum `frame_state_t` {IDLE, SHIFT, DONE}.
- Sub-module `smart_led_in_sync`: 2-FF synchronizers for both lines plus the edge detector. Outputs are the sampled bit, the edge pulse and the synchronized clock.

## Test plan
- Frame with data 30'h1234_5678, flag 0, good parity, then 1000 idle clk:
  - forwarded frame has flag 1 and good parity;
  - `led_data`=30'h1234_5678 with a one-cycle `led_valid`.
- Two back-to-back good frames (A=30'h0000_0001, B=30'h3FFF_FFFF), both flag 0:
  - A is claimed; B is forwarded bit-exact with flag 0;
  - after timeout `led_data`=30'h1.
- Frame 30'h0AAA_AAAA with parity flipped:
  - `parity_error` pulses and nothing is claimed;
  - forwarded frame has flag 1 and bad parity;
  - a following good frame 30'h155 is claimed and latched.
- 17 bits, then timeout:
  - `frame_error` pulses, `led_valid` stays 0, `led_data` unchanged;
  - next full frame is received from bit 0.
- `rst_n` low at bit 12 of a frame:
  - all outputs 0 within the reset cycle;
  - after release, a full frame 30'h2222_2222 is claimed and latched.
- `SMART_LED_PARITY_CHECK_EN` undefined, frame 30'h1 with bad parity:
  - claimed and latched;
  - `parity_error` stays 0;
  - forwarded parity is correct.
